// File: rtl/debug_scan_reader.sv
// Debug mux scanner: walks the mux select over all potential slots and the
// spike vector, streams HDR + samples (+ optional mod-256 sum) over valid/ready.
// Ports: clk, rst (async high); start/busy/done frame control;
//   cfg_out/cfg_en mux select write; dbg_in mux data; tx_data/tx_valid/tx_ready.
// Macro DEBUG_SCAN_CHECKSUM_EN appends the payload checksum byte.
module debug_scan_reader #(
  parameter int          NUM_POT   = 16,
  parameter logic [7:0]  SPIKE_SEL = 8'h10,
  parameter logic [7:0]  PARK_SEL  = 8'h10,
  parameter logic [7:0]  HDR_BYTE  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] cfg_out,
  output logic       cfg_en,
  input  logic [7:0] dbg_in,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  localparam int IW = $clog2(NUM_POT + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_POT);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    SEL,
    SAMPLE,
    SEND,
`ifdef DEBUG_SCAN_CHECKSUM_EN
    CSUM,
`endif
    PARK,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          busy_d, done_d, cfg_en_d, tx_valid_d;
  logic [7:0]    cfg_out_d, tx_data_d;
  logic          xfer;
`ifdef DEBUG_SCAN_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d;
`endif

  // Slots below NUM_POT select a potential; the slot past them is the spikes.
  function automatic logic [7:0] sel_of(input logic [IW-1:0] i);
    return (i < LAST) ? 8'(i) : SPIKE_SEL;
  endfunction

  assign xfer = tx_valid & tx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cfg_out  <= 8'h00;
      cfg_en   <= 1'b0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
`ifdef DEBUG_SCAN_CHECKSUM_EN
      sum_q    <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      busy     <= busy_d;
      done     <= done_d;
      cfg_out  <= cfg_out_d;
      cfg_en   <= cfg_en_d;
      tx_data  <= tx_data_d;
      tx_valid <= tx_valid_d;
`ifdef DEBUG_SCAN_CHECKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  // Outputs are next-state values registered above, so each strobe
  // is high during the cycle its state is occupied.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    busy_d     = busy;
    done_d     = 1'b0;
    cfg_en_d   = 1'b0;
    cfg_out_d  = cfg_out;
    tx_data_d  = tx_data;
    tx_valid_d = tx_valid;
`ifdef DEBUG_SCAN_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    unique case (state_q)
      IDLE: begin
        idx_d = '0;
`ifdef DEBUG_SCAN_CHECKSUM_EN
        sum_d = 8'h00;
`endif
        if (start) begin
          state_d    = HDR;
          busy_d     = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = HDR_BYTE;
        end
      end
      HDR: begin
        if (xfer) begin
          tx_valid_d = 1'b0;
          state_d    = SEL;
          cfg_en_d   = 1'b1;
          cfg_out_d  = sel_of(idx_q);
        end
      end
      SEL: state_d = SAMPLE;
      SAMPLE: begin
        tx_data_d  = dbg_in;
        tx_valid_d = 1'b1;
`ifdef DEBUG_SCAN_CHECKSUM_EN
        sum_d      = sum_q + dbg_in;
`endif
        state_d    = SEND;
      end
      SEND: begin
        if (xfer) begin
          tx_valid_d = 1'b0;
          if (idx_q == LAST) begin
`ifdef DEBUG_SCAN_CHECKSUM_EN
            tx_valid_d = 1'b1;
            tx_data_d  = sum_q;
            state_d    = CSUM;
`else
            state_d    = PARK;
            cfg_en_d   = 1'b1;
            cfg_out_d  = PARK_SEL;
`endif
          end else begin
            idx_d     = idx_q + 1'b1;
            state_d   = SEL;
            cfg_en_d  = 1'b1;
            cfg_out_d = sel_of(idx_q + 1'b1);
          end
        end
      end
`ifdef DEBUG_SCAN_CHECKSUM_EN
      CSUM: begin
        if (xfer) begin
          tx_valid_d = 1'b0;
          state_d    = PARK;
          cfg_en_d   = 1'b1;
          cfg_out_d  = PARK_SEL;
        end
      end
`endif
      PARK: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_debug_scan_reader.sv
// Bench for debug_scan_reader: mux model, byte scoreboard, latency,
// backpressure hold, dropped starts and mid-frame reset.
module tb_debug_scan_reader;

`ifdef DEBUG_SCAN_CHECKSUM_EN
  localparam int LAT   = 55;
  localparam int FRAME = 19;
`else
  localparam int LAT   = 54;
  localparam int FRAME = 18;
`endif

  logic       clk = 1'b0;
  logic       rst, start, tx_ready;
  logic       busy, done, cfg_en, tx_valid;
  logic [7:0] cfg_out, dbg_in, tx_data;

  always #5 clk = ~clk;

  debug_scan_reader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .cfg_out  (cfg_out),
    .cfg_en   (cfg_en),
    .dbg_in   (dbg_in),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  logic [7:0] mux_sel;
  logic [7:0] ofs;

  always_ff @(posedge clk or posedge rst)
    if (rst) mux_sel <= 8'h00;
    else if (cfg_en) mux_sel <= cfg_out;

  always_comb begin
    dbg_in = 8'hEE;
    if (mux_sel < 8'd16) dbg_in = mux_sel * 8'd3 + ofs;
    else if (mux_sel == 8'h10) dbg_in = 8'h5C ^ ofs;
  end

  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] q[$];
  int         nbytes = 0;
  int         nen = 0;
  int         stall_cnt = 0;
  bit         bp = 0;
  bit         pv_stall = 0;
  logic [7:0] pd;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic push_frame();
    logic [7:0] s, b;
    s = 8'h00;
    q.push_back(8'hA5);
    for (int i = 0; i < 16; i++) begin
      b = 8'(i * 3) + ofs;
      s = s + b;
      q.push_back(b);
    end
    b = 8'h5C ^ ofs;
    s = s + b;
    q.push_back(b);
`ifdef DEBUG_SCAN_CHECKSUM_EN
    q.push_back(s);
`endif
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (pv_stall) begin
        chk("hold_valid", tx_valid, 1);
        chk("hold_data", tx_data, pd);
      end
      pv_stall = tx_valid && !tx_ready;
      pd = tx_data;
      if (cfg_en) nen++;
      if (tx_valid && tx_ready) begin
        if (q.size() == 0) chk("extra_byte", 1, 0);
        else chk($sformatf("byte%0d", nbytes), tx_data, q.pop_front());
        nbytes++;
        stall_cnt = 0;
      end
    end else begin
      pv_stall = 0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_ready = !(bp && tx_valid && (nbytes % 3 == 2) && stall_cnt < 5);
      if (!tx_ready) stall_cnt++;
    end
  end

  task automatic run_frame(input bit mid_start, input int rst_at,
                           input bit chk_lat);
    int n;
    nbytes = 0;
    nen = 0;
    push_frame();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (n = 1; n < 2000; n++) begin
      @(negedge clk);
      if (n == 1) chk("busy_rise", {busy, tx_valid, tx_data}, {2'b11, 8'hA5});
      if (mid_start && n == 20) start = 1'b1;
      if (mid_start && n == 21) start = 1'b0;
      if (n == rst_at) begin
        #1 rst = 1'b1;
        #1 chk("rst_abort", {busy, done, cfg_en, tx_valid, cfg_out, tx_data}, 0);
        @(negedge clk);
        chk("rst_hold", {busy, done, cfg_en, tx_valid, cfg_out, tx_data}, 0);
        rst = 1'b0;
        q.delete();
        return;
      end
      if (done) break;
    end
    if (!done) chk("done_timeout", 0, 1);
    if (chk_lat) chk("done_latency", n, LAT);
    if (mid_start) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("busy_fall", {busy, done}, 0);
    chk("park_sel", cfg_out, 8'h10);
    chk("cfg_pulses", nen, 18);
    chk("frame_len", nbytes, FRAME);
    chk("queue_empty", q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    tx_ready = 1'b1;
    ofs = 8'h00;
    #1;
    chk("reset_out", {busy, done, cfg_en, tx_valid, cfg_out, tx_data}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    run_frame(0, -1, 1);

    ofs = 8'h07;
    bp = 1;
    run_frame(0, -1, 0);
    bp = 0;

    ofs = 8'h21;
    run_frame(1, -1, 1);
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("no_second_frame", nbytes, FRAME);
    chk("idle_busy", busy, 0);

    ofs = 8'h00;
    run_frame(0, 25, 0);
    repeat (3) @(posedge clk);

    ofs = 8'h40;
    run_frame(0, -1, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
